cu_sequencer: RTL and testbench



---
 rtl/cu_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_cu_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// cu_sequencer: top-level control sequencer for the single-datapath CPU.
// Fetches an instruction, classifies its opcode into a decoder class (R, I,
// D, B), steps the selected combinational decoder through its states and
// forwards that decoder's control word to the datapath. Stalls on slow
// memory. Halts on illegal opcodes and on HLT.
//
// Optional feature: define CU_SEQ_STALL_TIMEOUT_EN to add a stall watchdog.
// The FSM then halts with fault=3 after TIMEOUT consecutive mem_ready-low
// cycles in FETCH or in stalled EXEC cycles.
module cu_sequencer #(
    parameter int CUL     = 36,
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [31:0]    IR,
    input  logic [3:0]     status,
    input  logic           mem_ready,
    input  logic [CUL:0]   dec_cw,
    input  logic [2:0]     dec_NS,
    output logic [CUL:0]   controlWord,
    output logic [3:0]     state,
    output logic [2:0]     k_sel,
    output logic           instr_done,
    output logic           halted,
    output logic [1:0]     fault
);

    // Control word bit positions used by the sequencer itself.
    localparam int CW_W_REG       = 15;
    localparam int CW_MEM_CS_HI   = 13;
    localparam int CW_MEM_CS_LO   = 12;
    localparam int CW_IR_LOAD     = 9;
    localparam int CW_STATUS_LOAD = 8;
    localparam int CW_ADD_TRI     = 5;
    localparam int CW_DATA_TRI_HI = 4;
    localparam int CW_DATA_TRI_LO = 3;
    localparam int CW_PC_FS_HI    = 1;
    localparam int CW_PC_FS_LO    = 0;

    localparam logic [31:0] HLT_OPCODE = 32'hD440_0000;

    localparam logic [2:0] K_R    = 3'd0;
    localparam logic [2:0] K_I    = 3'd1;
    localparam logic [2:0] K_D    = 3'd2;
    localparam logic [2:0] K_B    = 3'd3;
    localparam logic [2:0] K_NONE = 3'd7;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_HLT     = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [2:0] state_q, state_d;
    logic [2:0] k_sel_d;
    logic [1:0] fault_d;
    logic       halted_d;
    logic       done_d;

    // NZCV flags go straight to the decoders; the sequencer never looks at them.
    logic [3:0] unused_status;
    assign unused_status = status;

    // A memory EXEC cycle waits for mem_ready; all other cycles ignore it.
    logic mem_access;
    logic exec_stall;
    logic fetch_stall;
    assign mem_access  = |dec_cw[CW_MEM_CS_HI:CW_MEM_CS_LO];
    assign exec_stall  = (fsm_q == S_EXEC) && mem_access && !mem_ready;
    assign fetch_stall = (fsm_q == S_FETCH) && !mem_ready;

    logic timeout_hit;

`ifdef CU_SEQ_STALL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_any;
    assign stall_any = fetch_stall || exec_stall;

    // Count consecutive stall cycles; any completed access restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (mem_ready) begin
            stall_cnt <= '0;
        end else if (stall_any) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // The TIMEOUT-th stall cycle is the last one; its closing edge enters HALT.
    assign timeout_hit = stall_any && (stall_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    logic        unused_fetch_stall;
    assign unused_timeout     = 32'(TIMEOUT);
    assign unused_fetch_stall = fetch_stall;
    assign timeout_hit        = 1'b0;
`endif

    // Next-state logic: FSM transitions plus the values of every registered output.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        fsm_d    = fsm_q;
        state_d  = state_q;
        k_sel_d  = k_sel;
        fault_d  = fault;
        halted_d = halted;
        done_d   = 1'b0;

        unique case (fsm_q)
            S_RST: begin
                fsm_d = S_FETCH;
            end

            S_FETCH: begin
                if (timeout_hit) begin
                    fsm_d    = S_HALT;
                    fault_d  = FAULT_TIMEOUT;
                    halted_d = 1'b1;
                end else if (mem_ready) begin
                    fsm_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // First match wins; HLT is checked before any class pattern.
                fsm_d   = S_EXEC;
                state_d = 3'd0;
                if (IR == HLT_OPCODE) begin
                    k_sel_d  = K_NONE;
                    fsm_d    = S_HALT;
                    state_d  = state_q;
                    fault_d  = FAULT_HLT;
                    halted_d = 1'b1;
                end else if (IR[28:26] == 3'b101) begin
                    k_sel_d = K_B;
                end else if (IR[27] && !IR[25]) begin
                    k_sel_d = K_D;
                end else if (IR[28:26] == 3'b100) begin
                    k_sel_d = K_I;
                end else if (IR[27:25] == 3'b101) begin
                    k_sel_d = K_R;
                end else begin
                    k_sel_d  = K_NONE;
                    fsm_d    = S_HALT;
                    state_d  = state_q;
                    fault_d  = FAULT_ILLEGAL;
                    halted_d = 1'b1;
                end
            end

            S_EXEC: begin
                if (timeout_hit) begin
                    fsm_d    = S_HALT;
                    fault_d  = FAULT_TIMEOUT;
                    halted_d = 1'b1;
                end else if (exec_stall) begin
                    fsm_d = S_EXEC;
                end else if (dec_NS == 3'd0) begin
                    done_d = 1'b1;
                    fsm_d  = S_FETCH;
                end else begin
                    state_d = dec_NS;
                end
            end

            S_HALT: begin
                fsm_d = S_HALT;
            end

            default: begin
                fsm_d = S_RST;
            end
        endcase
    end

    // State register and registered outputs; reset lands in RST with everything cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= S_RST;
            state_q    <= 3'd0;
            k_sel      <= K_R;
            fault      <= FAULT_NONE;
            halted     <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            k_sel      <= k_sel_d;
            fault      <= fault_d;
            halted     <= halted_d;
            instr_done <= done_d;
        end
    end

    assign state = {1'b0, state_q};

    // Control word to the datapath: fixed patterns for FETCH, decoder word in EXEC, NOP otherwise.
    always_comb begin
        controlWord = '0;
        unique case (fsm_q)
            S_FETCH: begin
                controlWord[CW_MEM_CS_HI:CW_MEM_CS_LO]     = 2'b01;
                controlWord[CW_ADD_TRI]                    = 1'b1;
                controlWord[CW_DATA_TRI_HI:CW_DATA_TRI_LO] = 2'b01;
                if (mem_ready) begin
                    controlWord[CW_IR_LOAD]               = 1'b1;
                    controlWord[CW_PC_FS_HI:CW_PC_FS_LO]  = 2'b01;
                end
            end
            S_EXEC: begin
                controlWord = dec_cw;
                // A stalled memory cycle must not commit any architectural state.
                if (exec_stall) begin
                    controlWord[CW_W_REG]                = 1'b0;
                    controlWord[CW_STATUS_LOAD]          = 1'b0;
                    controlWord[CW_IR_LOAD]              = 1'b0;
                    controlWord[CW_PC_FS_HI:CW_PC_FS_LO] = 2'b00;
                end
            end
            default: begin
                controlWord = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Testbench for cu_sequencer: directed sequence of instructions. Each cycle
// pushes its expected outputs to a scoreboard queue, then pops and compares
// them mid-cycle. instr_done is registered, so it shows up in the cycle after
// the completing EXEC cycle.
module tb_cu_sequencer;

    localparam int CUL = 36;

    logic           clock;
    logic           reset_n;
    logic [31:0]    IR;
    logic [3:0]     status;
    logic           mem_ready;
    logic [CUL:0]   dec_cw;
    logic [2:0]     dec_NS;
    logic [CUL:0]   controlWord;
    logic [3:0]     state;
    logic [2:0]     k_sel;
    logic           instr_done;
    logic           halted;
    logic [1:0]     fault;

    cu_sequencer #(.CUL(CUL), .TIMEOUT(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .IR          (IR),
        .status      (status),
        .mem_ready   (mem_ready),
        .dec_cw      (dec_cw),
        .dec_NS      (dec_NS),
        .controlWord (controlWord),
        .state       (state),
        .k_sel       (k_sel),
        .instr_done  (instr_done),
        .halted      (halted),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        tag;
        logic [CUL:0] cw;
        logic [3:0]   st;
        logic [2:0]   ks;
        logic         done;
        logic         halt;
        logic [1:0]   flt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [CUL:0] NOP    = '0;
    localparam logic [CUL:0] F_WAIT = 37'h0_0000_1028;  // mem_cs=01, add_tri=1, data_tri=01
    localparam logic [CUL:0] F_RDY  = 37'h0_0000_1229;  // plus IR_load and PC_FS=01

    task automatic check(input string name, input logic [CUL:0] obs, input logic [CUL:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "/cw"},     controlWord,          e.cw);
        check({e.tag, "/state"},  37'(state),           37'(e.st));
        check({e.tag, "/k_sel"},  37'(k_sel),           37'(e.ks));
        check({e.tag, "/done"},   37'(instr_done),      37'(e.done));
        check({e.tag, "/halted"}, 37'(halted),          37'(e.halt));
        check({e.tag, "/fault"},  37'(fault),           37'(e.flt));
    endtask

    // Entered just after a rising edge: drive inputs, record expectation,
    // compare mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [31:0] ir, input logic mr,
                       input logic [CUL:0] dcw, input logic [2:0] ns,
                       input logic [CUL:0] e_cw, input logic [3:0] e_st, input logic [2:0] e_ks,
                       input logic e_done, input logic e_halt, input logic [1:0] e_flt);
        exp_t e;
        IR        = ir;
        mem_ready = mr;
        dec_cw    = dcw;
        dec_NS    = ns;
        e.tag = tag; e.cw = e_cw; e.st = e_st; e.ks = e_ks;
        e.done = e_done; e.halt = e_halt; e.flt = e_flt;
        sb.push_back(e);
        #3;
        compare_front();
        @(posedge clock);
        #1;
    endtask

    localparam logic [CUL:0] CW_R     = 37'h0_8A01_8024;  // ALU op, w_reg=1, no memory
    localparam logic [CUL:0] CW_D     = 37'h0_4000_9101;  // mem_cs=01, w_reg, status_load, PC_FS=01
    localparam logic [CUL:0] CW_D_STL = 37'h0_4000_1000;  // CW_D with commit bits cleared
    localparam logic [CUL:0] CW_B0    = 37'h0_0000_0004;
    localparam logic [CUL:0] CW_B1    = 37'h0_0000_0006;

    initial begin
        reset_n   = 1'b0;
        IR        = '0;
        status    = 4'b1010;
        mem_ready = 1'b1;
        dec_cw    = '0;
        dec_NS    = '0;
        repeat (2) @(posedge clock);
        #1;
        cyc("in_reset", 32'h0, 1'b1, CW_R, 3'd0, NOP, 4'd0, 3'd0, 0, 0, 2'd0);
        reset_n = 1'b1;

        // Reset release, then R-type ADD: FETCH, DECODE, one EXEC cycle.
        cyc("rst_nop",   32'h8B02_0020, 1'b1, CW_R, 3'd0, NOP,    4'd0, 3'd0, 0, 0, 2'd0);
        cyc("r_fetch",   32'h8B02_0020, 1'b1, CW_R, 3'd0, F_RDY,  4'd0, 3'd0, 0, 0, 2'd0);
        cyc("r_decode",  32'h8B02_0020, 1'b1, CW_R, 3'd0, NOP,    4'd0, 3'd0, 0, 0, 2'd0);
        cyc("r_exec",    32'h8B02_0020, 1'b1, CW_R, 3'd0, CW_R,   4'd0, 3'd0, 0, 0, 2'd0);
        cyc("fetch_wait",32'h8B02_0020, 1'b0, CW_R, 3'd0, F_WAIT, 4'd0, 3'd0, 1, 0, 2'd0);

        // D-type load with three stalled EXEC cycles.
        cyc("d_fetch",   32'hF840_0020, 1'b1, CW_D, 3'd0, F_RDY,    4'd0, 3'd0, 0, 0, 2'd0);
        cyc("d_decode",  32'hF840_0020, 1'b1, CW_D, 3'd0, NOP,      4'd0, 3'd0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++)
            cyc("d_stall", 32'hF840_0020, 1'b0, CW_D, 3'd0, CW_D_STL, 4'd0, 3'd2, 0, 0, 2'd0);
        cyc("d_exec",    32'hF840_0020, 1'b1, CW_D, 3'd0, CW_D,     4'd0, 3'd2, 0, 0, 2'd0);

        // Branch with two decoder states.
        cyc("b_fetch",   32'h1400_0004, 1'b1, CW_B0, 3'd0, F_RDY, 4'd0, 3'd2, 1, 0, 2'd0);
        cyc("b_decode",  32'h1400_0004, 1'b1, CW_B0, 3'd0, NOP,   4'd0, 3'd2, 0, 0, 2'd0);
        cyc("b_exec0",   32'h1400_0004, 1'b0, CW_B0, 3'd1, CW_B0, 4'd0, 3'd3, 0, 0, 2'd0);
        cyc("b_exec1",   32'h1400_0004, 1'b1, CW_B1, 3'd0, CW_B1, 4'd1, 3'd3, 0, 0, 2'd0);

        // Illegal opcode: HALT with fault=1, NOP held regardless of inputs.
        cyc("ill_fetch",  32'h0000_0000, 1'b1, CW_R, 3'd0, F_RDY, 4'd1, 3'd3, 1, 0, 2'd0);
        cyc("ill_decode", 32'h0000_0000, 1'b1, CW_R, 3'd0, NOP,   4'd1, 3'd3, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++)
            cyc("ill_halt", 32'h8B02_0020, i[0], CW_D, 3'd2, NOP, 4'd1, 3'd7, 0, 1, 2'd1);

        // Reset out of HALT is immediate, then HLT instruction.
        reset_n = 1'b0;
        cyc("rst_assert", 32'hD440_0000, 1'b1, CW_R, 3'd0, NOP, 4'd0, 3'd0, 0, 0, 2'd0);
        reset_n = 1'b1;
        cyc("hlt_rst",    32'hD440_0000, 1'b1, CW_R, 3'd0, NOP,   4'd0, 3'd0, 0, 0, 2'd0);
        cyc("hlt_fetch",  32'hD440_0000, 1'b1, CW_R, 3'd0, F_RDY, 4'd0, 3'd0, 0, 0, 2'd0);
        cyc("hlt_decode", 32'hD440_0000, 1'b1, CW_R, 3'd0, NOP,   4'd0, 3'd0, 0, 0, 2'd0);
        cyc("hlt_halt",   32'hD440_0000, 1'b1, CW_R, 3'd0, NOP,   4'd0, 3'd7, 0, 1, 2'd2);

        // Fetch stall: watchdog build halts after 4 stall cycles, default build never does.
        reset_n = 1'b0;
        cyc("rst_assert2", 32'h8B02_0020, 1'b0, CW_R, 3'd0, NOP, 4'd0, 3'd0, 0, 0, 2'd0);
        reset_n = 1'b1;
        cyc("stall_rst",  32'h8B02_0020, 1'b0, CW_R, 3'd0, NOP, 4'd0, 3'd0, 0, 0, 2'd0);
        for (int i = 0; i < 4; i++)
            cyc("stall_fetch", 32'h8B02_0020, 1'b0, CW_R, 3'd0, F_WAIT, 4'd0, 3'd0, 0, 0, 2'd0);
`ifdef CU_SEQ_STALL_TIMEOUT_EN
        cyc("timeout_halt", 32'h8B02_0020, 1'b0, CW_R, 3'd0, NOP, 4'd0, 3'd0, 0, 1, 2'd3);
`else
        for (int i = 4; i < 1000; i++)
            cyc("stall_long", 32'h8B02_0020, 1'b0, CW_R, 3'd0, F_WAIT, 4'd0, 3'd0, 0, 0, 2'd0);
        cyc("stall_release", 32'h8B02_0020, 1'b1, CW_R, 3'd0, F_RDY, 4'd0, 3'd0, 0, 0, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
